// File: rtl/biu_arbiter_2to1.sv
// Arbitrates the instruction and data cache ports onto one BIU; request path is combinational (zero latency).
// Backpressure: the losing port holds stb until the owner has no beats in flight and drops stb/lock.
package biu_arbiter_2to1_pkg;
    typedef logic [2:0] biu_size_t;
    typedef logic [2:0] biu_type_t;
    typedef logic [3:0] biu_prot_t;

    localparam biu_type_t SINGLE = 3'd0;
    localparam biu_type_t INCR   = 3'd1;
    localparam biu_type_t WRAP4  = 3'd2;
    localparam biu_type_t INCR4  = 3'd3;
    localparam biu_type_t WRAP8  = 3'd4;
    localparam biu_type_t INCR8  = 3'd5;
    localparam biu_type_t WRAP16 = 3'd6;
    localparam biu_type_t INCR16 = 3'd7;
endpackage

module biu_arbiter_2to1
    import biu_arbiter_2to1_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = DATA_SIZE
) (
    input  logic                 HCLK,
    input  logic                 HRESET,

    input  logic                 ibiu_stb_i,
    output logic                 ibiu_stb_ack_o,
    output logic                 ibiu_d_ack_o,
    input  logic [ADDR_SIZE-1:0] ibiu_adri_i,
    output logic [ADDR_SIZE-1:0] ibiu_adro_o,
    input  biu_size_t            ibiu_size_i,
    input  biu_type_t            ibiu_type_i,
    input  biu_prot_t            ibiu_prot_i,
    input  logic                 ibiu_lock_i,
    input  logic                 ibiu_we_i,
    input  logic [DATA_SIZE-1:0] ibiu_d_i,
    output logic [DATA_SIZE-1:0] ibiu_q_o,
    output logic                 ibiu_ack_o,
    output logic                 ibiu_err_o,

    input  logic                 dbiu_stb_i,
    output logic                 dbiu_stb_ack_o,
    output logic                 dbiu_d_ack_o,
    input  logic [ADDR_SIZE-1:0] dbiu_adri_i,
    output logic [ADDR_SIZE-1:0] dbiu_adro_o,
    input  biu_size_t            dbiu_size_i,
    input  biu_type_t            dbiu_type_i,
    input  biu_prot_t            dbiu_prot_i,
    input  logic                 dbiu_lock_i,
    input  logic                 dbiu_we_i,
    input  logic [DATA_SIZE-1:0] dbiu_d_i,
    output logic [DATA_SIZE-1:0] dbiu_q_o,
    output logic                 dbiu_ack_o,
    output logic                 dbiu_err_o,

    output logic                 biu_stb_o,
    input  logic                 biu_stb_ack_i,
    input  logic                 biu_d_ack_i,
    output logic [ADDR_SIZE-1:0] biu_adri_o,
    input  logic [ADDR_SIZE-1:0] biu_adro_i,
    output biu_size_t            biu_size_o,
    output biu_type_t            biu_type_o,
    output biu_prot_t            biu_prot_o,
    output logic                 biu_lock_o,
    output logic                 biu_we_o,
    output logic [DATA_SIZE-1:0] biu_d_o,
    input  logic [DATA_SIZE-1:0] biu_q_i,
    input  logic                 biu_ack_i,
    input  logic                 biu_err_i
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} fsm_t;

    fsm_t       state, state_nxt;
    logic       owner, owner_nxt;
    logic       last_grant, last_grant_nxt;
    logic [5:0] pending, pending_nxt;
    logic [5:0] burst_len;
    logic       sel, sel_stb, sel_lock;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            pending    <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            pending    <= pending_nxt;
        end
    end

    // In IDLE a tie goes to the port that did not win last; with no request sel stays on the owner.
    always_comb begin
        sel = owner;
        if (state == IDLE) begin
            if (ibiu_stb_i && dbiu_stb_i) sel = ~last_grant;
            else if (dbiu_stb_i)          sel = 1'b1;
            else if (ibiu_stb_i)          sel = 1'b0;
        end
    end

    assign sel_stb    = sel ? dbiu_stb_i  : ibiu_stb_i;
    assign sel_lock   = sel ? dbiu_lock_i : ibiu_lock_i;
    assign biu_adri_o = sel ? dbiu_adri_i : ibiu_adri_i;
    assign biu_size_o = sel ? dbiu_size_i : ibiu_size_i;
    assign biu_type_o = sel ? dbiu_type_i : ibiu_type_i;
    assign biu_prot_o = sel ? dbiu_prot_i : ibiu_prot_i;
    assign biu_lock_o = sel_lock;
    assign biu_we_o   = sel ? dbiu_we_i   : ibiu_we_i;
    assign biu_d_o    = sel ? dbiu_d_i    : ibiu_d_i;

    assign ibiu_q_o    = biu_q_i;
    assign dbiu_q_o    = biu_q_i;
    assign ibiu_adro_o = biu_adro_i;
    assign dbiu_adro_o = biu_adro_i;

    always_comb begin
        case (biu_type_o)
            WRAP4,  INCR4:  burst_len = 6'd4;
            WRAP8,  INCR8:  burst_len = 6'd8;
            WRAP16, INCR16: burst_len = 6'd16;
            default:        burst_len = 6'd1;
        endcase
    end

    // An error flushes every outstanding beat; a stray ack never wraps the counter below zero.
    always_comb begin
        pending_nxt = pending;
        if (biu_err_i) begin
            pending_nxt = '0;
        end else begin
            if (biu_stb_ack_i)                   pending_nxt = pending_nxt + burst_len;
            if (biu_ack_i && pending_nxt != '0) pending_nxt = pending_nxt - 6'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: if (ibiu_stb_i || dbiu_stb_i) begin
                state_nxt      = BUSY;
                owner_nxt      = sel;
                last_grant_nxt = sel;
            end
            BUSY: if (pending_nxt == '0 && !biu_stb_ack_i && !sel_stb && !sel_lock)
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        biu_stb_o      = 1'b0;
        ibiu_stb_ack_o = 1'b0;
        dbiu_stb_ack_o = 1'b0;
        ibiu_d_ack_o   = 1'b0;
        dbiu_d_ack_o   = 1'b0;
        ibiu_ack_o     = 1'b0;
        dbiu_ack_o     = 1'b0;
        ibiu_err_o     = 1'b0;
        dbiu_err_o     = 1'b0;
        if (!HRESET) begin
            biu_stb_o = sel_stb;
            if (sel) begin
                dbiu_stb_ack_o = biu_stb_ack_i;
                dbiu_d_ack_o   = biu_d_ack_i;
                dbiu_ack_o     = biu_ack_i;
                dbiu_err_o     = biu_err_i;
            end else begin
                ibiu_stb_ack_o = biu_stb_ack_i;
                ibiu_d_ack_o   = biu_d_ack_i;
                ibiu_ack_o     = biu_ack_i;
                ibiu_err_o     = biu_err_i;
            end
        end
    end

    ack_without_pending: assert property (@(posedge HCLK) disable iff (HRESET)
        !(biu_ack_i && !biu_stb_ack_i && pending == '0));

endmodule

// File: tb/tb_biu_arbiter_2to1.sv
// Scoreboarded bench for biu_arbiter_2to1: scripted masters on both ports and a reactive BIU model.
module tb_biu_arbiter_2to1;
    import biu_arbiter_2to1_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        ibiu_stb_i, dbiu_stb_i, ibiu_lock_i, dbiu_lock_i, ibiu_we_i, dbiu_we_i;
    logic        ibiu_stb_ack_o, dbiu_stb_ack_o, ibiu_d_ack_o, dbiu_d_ack_o;
    logic        ibiu_ack_o, dbiu_ack_o, ibiu_err_o, dbiu_err_o;
    logic [31:0] ibiu_adri_i, dbiu_adri_i, ibiu_adro_o, dbiu_adro_o;
    logic [31:0] ibiu_d_i, dbiu_d_i, ibiu_q_o, dbiu_q_o;
    biu_size_t   ibiu_size_i, dbiu_size_i, biu_size_o;
    biu_type_t   ibiu_type_i, dbiu_type_i, biu_type_o;
    biu_prot_t   ibiu_prot_i, dbiu_prot_i, biu_prot_o;
    logic        biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_lock_o, biu_we_o, biu_ack_i, biu_err_i;
    logic [31:0] biu_adri_o, biu_adro_i, biu_d_o, biu_q_i;

    biu_arbiter_2to1 #(.DATA_SIZE(32), .ADDR_SIZE(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .ibiu_stb_i(ibiu_stb_i), .ibiu_stb_ack_o(ibiu_stb_ack_o), .ibiu_d_ack_o(ibiu_d_ack_o),
        .ibiu_adri_i(ibiu_adri_i), .ibiu_adro_o(ibiu_adro_o), .ibiu_size_i(ibiu_size_i),
        .ibiu_type_i(ibiu_type_i), .ibiu_prot_i(ibiu_prot_i), .ibiu_lock_i(ibiu_lock_i),
        .ibiu_we_i(ibiu_we_i), .ibiu_d_i(ibiu_d_i), .ibiu_q_o(ibiu_q_o),
        .ibiu_ack_o(ibiu_ack_o), .ibiu_err_o(ibiu_err_o),
        .dbiu_stb_i(dbiu_stb_i), .dbiu_stb_ack_o(dbiu_stb_ack_o), .dbiu_d_ack_o(dbiu_d_ack_o),
        .dbiu_adri_i(dbiu_adri_i), .dbiu_adro_o(dbiu_adro_o), .dbiu_size_i(dbiu_size_i),
        .dbiu_type_i(dbiu_type_i), .dbiu_prot_i(dbiu_prot_i), .dbiu_lock_i(dbiu_lock_i),
        .dbiu_we_i(dbiu_we_i), .dbiu_d_i(dbiu_d_i), .dbiu_q_o(dbiu_q_o),
        .dbiu_ack_o(dbiu_ack_o), .dbiu_err_o(dbiu_err_o),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
        .biu_adri_o(biu_adri_o), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
        .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i),
        .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {logic [31:0] adr; biu_type_t btype;} req_t;
    typedef struct packed {bit port; int k; logic [31:0] adr; logic [31:0] data;} beat_t;

    localparam logic [31:0] I_WDATA = 32'hD0D0_0001;
    localparam logic [31:0] D_WDATA = 32'hD0D0_0002;

    req_t  iq[$], dq[$];
    beat_t exp_q[$];
    int    m_owner = -1;
    bit    m_last  = 1'b1;
    bit    rst_req = 1'b0, beat_en = 1'b1, accept_en = 1'b1, err_arm = 1'b0;
    bit    i_lock = 1'b0, d_lock = 1'b0;
    int    n_checks = 0, n_errors = 0;
    int    pend_peak = 0, i_ack_cnt = 0, d_ack_cnt = 0, i_err_cnt = 0, i_sack_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int blen(input biu_type_t t);
        case (t)
            WRAP4,  INCR4:  return 4;
            WRAP8,  INCR8:  return 8;
            WRAP16, INCR16: return 16;
            default:        return 1;
        endcase
    endfunction

    // One bus cycle: drive at negedge, let the BIU model react, check, then advance the reference model.
    task automatic tick();
        int   sel;
        bit   i_req, d_req, owned, exp_bstb, have_beat, olock, bport;
        req_t r;
        @(negedge HCLK);
        HRESET = rst_req;
        i_req = iq.size() > 0;
        d_req = dq.size() > 0;
        ibiu_stb_i = i_req;
        dbiu_stb_i = d_req;
        if (i_req) begin ibiu_adri_i = iq[0].adr; ibiu_type_i = iq[0].btype; end
        if (d_req) begin dbiu_adri_i = dq[0].adr; dbiu_type_i = dq[0].btype; end
        ibiu_lock_i = i_lock;
        dbiu_lock_i = d_lock;
        biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0;
        have_beat = !rst_req && beat_en && exp_q.size() > 0;
        bport = 1'b0;
        if (have_beat) begin
            bport      = exp_q[0].port;
            biu_q_i    = exp_q[0].data;
            biu_adro_i = exp_q[0].adr;
            if (err_arm && exp_q[0].k == 1) begin biu_err_i = 1'b1; err_arm = 1'b0; end
            else biu_ack_i = 1'b1;
        end
        owned = m_owner >= 0;
        if (rst_req)              sel = -1;
        else if (owned)           sel = m_owner;
        else if (i_req && d_req)  sel = m_last ? 0 : 1;
        else if (d_req)           sel = 1;
        else if (i_req)           sel = 0;
        else                      sel = -1;
        exp_bstb = (sel == 0 && i_req) || (sel == 1 && d_req);
        olock = (sel == 1) ? d_lock : i_lock;
        #1;
        chk("pending", {58'd0, dut.pending}, exp_q.size());
        if (!rst_req && int'(dut.pending) > pend_peak) pend_peak = int'(dut.pending);
        chk("biu_stb", biu_stb_o, exp_bstb);
        if (exp_bstb) begin
            chk("biu_adri", biu_adri_o, (sel == 1) ? dq[0].adr : iq[0].adr);
            chk("biu_type", biu_type_o, (sel == 1) ? dq[0].btype : iq[0].btype);
            chk("biu_lock", biu_lock_o, olock);
            chk("biu_d", biu_d_o, (sel == 1) ? D_WDATA : I_WDATA);
            if (accept_en) begin biu_stb_ack_i = 1'b1; biu_d_ack_i = 1'b1; end
        end
        // Garbage handshakes while in reset must not leak to either port.
        if (rst_req) begin biu_stb_ack_i = 1'b1; biu_d_ack_i = 1'b1; biu_ack_i = 1'b1; biu_err_i = 1'b1; end
        #1;
        chk("i_stb_ack", ibiu_stb_ack_o, !rst_req && biu_stb_ack_i && sel == 0);
        chk("d_stb_ack", dbiu_stb_ack_o, !rst_req && biu_stb_ack_i && sel == 1);
        chk("i_d_ack",   ibiu_d_ack_o,   !rst_req && biu_d_ack_i && sel == 0);
        chk("d_d_ack",   dbiu_d_ack_o,   !rst_req && biu_d_ack_i && sel == 1);
        chk("i_ack", ibiu_ack_o, have_beat && biu_ack_i && !bport);
        chk("d_ack", dbiu_ack_o, have_beat && biu_ack_i && bport);
        chk("i_err", ibiu_err_o, have_beat && biu_err_i && !bport);
        chk("d_err", dbiu_err_o, have_beat && biu_err_i && bport);
        if (have_beat) begin
            chk("i_q", ibiu_q_o, exp_q[0].data);
            chk("d_q", dbiu_q_o, exp_q[0].data);
            chk("i_adro", ibiu_adro_o, exp_q[0].adr);
            chk("d_adro", dbiu_adro_o, exp_q[0].adr);
        end
        if (ibiu_ack_o) i_ack_cnt++;
        if (dbiu_ack_o) d_ack_cnt++;
        if (ibiu_err_o) i_err_cnt++;
        if (ibiu_stb_ack_o) i_sack_cnt++;
        if (rst_req) begin
            exp_q.delete();
            m_owner = -1;
            m_last  = 1'b1;
        end else begin
            if (biu_err_i) exp_q.delete();
            else if (biu_ack_i) void'(exp_q.pop_front());
            if (biu_stb_ack_i) begin
                if (sel == 1) r = dq.pop_front();
                else          r = iq.pop_front();
                for (int k = 0; k < blen(r.btype); k++)
                    exp_q.push_back('{port: (sel == 1), k: k, adr: r.adr + 32'(4 * k),
                                      data: r.adr ^ 32'hA5A5_0000 ^ 32'(k)});
            end
            if (!owned) begin
                if (exp_bstb) begin m_owner = sel; m_last = (sel == 1); end
            end else if (exp_q.size() == 0 && !biu_stb_ack_i && !exp_bstb && !olock) begin
                m_owner = -1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || iq.size() > 0 || dq.size() > 0 || m_owner >= 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size() + iq.size() + dq.size() + int'(m_owner >= 0), 0);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1;
        ibiu_stb_i = 1'b0; dbiu_stb_i = 1'b0; ibiu_lock_i = 1'b0; dbiu_lock_i = 1'b0;
        ibiu_adri_i = '0; dbiu_adri_i = '0; ibiu_type_i = SINGLE; dbiu_type_i = SINGLE;
        ibiu_size_i = 3'd2; dbiu_size_i = 3'd2; ibiu_prot_i = 4'h1; dbiu_prot_i = 4'h3;
        ibiu_we_i = 1'b0; dbiu_we_i = 1'b0; ibiu_d_i = I_WDATA; dbiu_d_i = D_WDATA;
        biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
        biu_adro_i = '0; biu_q_i = '0;

        do_reset();
        run(2);

        // Single I read, D idle.
        iq.push_back('{adr: 32'h100, btype: SINGLE});
        drain("t1_drain", 20);
        chk("t1_i_acks", i_ack_cnt, 1);
        chk("t1_d_acks", d_ack_cnt, 0);

        // Tie straight after reset: I first, then D's INCR8, then the next tie goes to I.
        do_reset();
        i_ack_cnt = 0; d_ack_cnt = 0;
        iq.push_back('{adr: 32'h110, btype: INCR4});
        dq.push_back('{adr: 32'h200, btype: INCR8});
        drain("t2_drain", 60);
        chk("t2_i_acks", i_ack_cnt, 4);
        chk("t2_d_acks", d_ack_cnt, 8);
        iq.push_back('{adr: 32'h120, btype: SINGLE});
        dq.push_back('{adr: 32'h210, btype: SINGLE});
        drain("t2_tie_drain", 30);

        // D WRAP4 then back-to-back SINGLE while beats are stalled; I must wait.
        pend_peak = 0; i_sack_cnt = 0;
        beat_en = 1'b0;
        dq.push_back('{adr: 32'h240, btype: WRAP4});
        dq.push_back('{adr: 32'h280, btype: SINGLE});
        tick();
        iq.push_back('{adr: 32'h300, btype: SINGLE});
        run(3);
        chk("t3_i_waits", i_sack_cnt, 0);
        beat_en = 1'b1;
        drain("t3_drain", 40);
        chk("t3_pend_peak", pend_peak, 5);
        chk("t3_i_sack", i_sack_cnt, 1);

        // Error on beat 2 of an I INCR4 while D waits.
        i_err_cnt = 0; i_ack_cnt = 0;
        err_arm = 1'b1;
        iq.push_back('{adr: 32'h400, btype: INCR4});
        tick();
        dq.push_back('{adr: 32'h500, btype: SINGLE});
        drain("t4_drain", 30);
        chk("t4_err_pulses", i_err_cnt, 1);
        chk("t4_i_acks", i_ack_cnt, 1);

        // D holds lock over two SINGLEs with an idle gap; I is locked out until lock drops.
        i_sack_cnt = 0;
        d_lock = 1'b1;
        dq.push_back('{adr: 32'h600, btype: SINGLE});
        tick();
        iq.push_back('{adr: 32'h700, btype: SINGLE});
        run(6);
        dq.push_back('{adr: 32'h610, btype: SINGLE});
        run(4);
        chk("t5_i_locked_out", i_sack_cnt, 0);
        d_lock = 1'b0;
        drain("t5_drain", 30);
        chk("t5_i_sack", i_sack_cnt, 1);

        // Reset with seven beats outstanding, both ports requesting.
        beat_en = 1'b0;
        dq.push_back('{adr: 32'h800, btype: INCR8});
        tick();
        beat_en = 1'b1;
        tick();
        beat_en = 1'b0; accept_en = 1'b0;
        iq.push_back('{adr: 32'h900, btype: SINGLE});
        dq.push_back('{adr: 32'h880, btype: SINGLE});
        tick();
        chk("t6_pend_pre_rst", {58'd0, dut.pending}, 7);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0; accept_en = 1'b1; beat_en = 1'b1;
        i_sack_cnt = 0;
        tick();
        chk("t6_i_first", i_sack_cnt, 1);
        drain("t6_drain", 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/biu_arbiter_2to1.md
Name: biu_arbiter_2to1

Overview:
- Two-port arbiter that sits directly upstream of the AHB3-Lite bus interface unit.
- Lets the instruction-side and data-side cache controllers share one BIU.
- Forwards the granted port's request combinationally, and tracks outstanding data beats so that stb_ack/d_ack/ack/err/q/adro reach the owner.
- Ownership changes only when the BIU pipeline holds no beats for the current owner.

Parameters:
- DATA_SIZE, 32, data width of BIU data buses.
- ADDR_SIZE, DATA_SIZE, address width.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- ibiu_stb_i, dbiu_stb_i  in  1  port strobe (I = instruction port, D = data port).
- ibiu_stb_ack_o, dbiu_stb_ack_o  out  1  strobe accepted.
- ibiu_d_ack_o, dbiu_d_ack_o  out  1  write-data acknowledge.
- ibiu_adri_i, dbiu_adri_i  in  ADDR_SIZE  request address.
- ibiu_adro_o, dbiu_adro_o  out  ADDR_SIZE  address of current data beat.
- ibiu_size_i, dbiu_size_i  in  biu_size_t  transfer size.
- ibiu_type_i, dbiu_type_i  in  biu_type_t  burst type.
- ibiu_prot_i, dbiu_prot_i  in  biu_prot_t  protection.
- ibiu_lock_i, dbiu_lock_i  in  1  lock request.
- ibiu_we_i, dbiu_we_i  in  1  write enable.
- ibiu_d_i, dbiu_d_i  in  DATA_SIZE  write data.
- ibiu_q_o, dbiu_q_o  out  DATA_SIZE  read data.
- ibiu_ack_o, dbiu_ack_o  out  1  beat complete.
- ibiu_err_o, dbiu_err_o  out  1  transfer error.
- biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o, biu_we_o, biu_d_o  out  (widths as above)  request to BIU.
- biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i  in  1  BIU handshakes.
- biu_adro_i  in  ADDR_SIZE  BIU data-beat address.
- biu_q_i  in  DATA_SIZE  BIU read data.

Behaviour:
- State: fsm {IDLE, BUSY}, owner (0 = I, 1 = D), last_grant, pending[5:0].
- Reset values: fsm = IDLE, owner = I, last_grant = D (so I wins the first tie), pending = 0.
- Output reset values: all *_stb_ack_o, *_d_ack_o, *_ack_o, *_err_o = 0; biu_stb_o = 0.
- Select:
  - In IDLE, sel = the requesting port; if both request, sel = the port != last_grant.
  - In BUSY, sel = owner.
- Request path:
  - All biu_* request outputs equal sel's inputs, zero latency.
  - biu_stb_o = sel's stb.
  - biu_lock_o = sel's lock.
- Response path:
  - stb_ack, d_ack, ack and err go to sel/owner only; the other port sees 0.
  - biu_q_i and biu_adro_i are broadcast to both q/adro outputs.
- IDLE -> BUSY when any stb is high: owner <= sel, last_grant <= sel. The selection is held from this point, so the request stays stable until stb_ack as the BIU requires.
- Beat length from type: SINGLE/INCR = 1, WRAP4/INCR4 = 4, WRAP8/INCR8 = 8, WRAP16/INCR16 = 16.
- pending update, 6-bit:
  - Normal: pending_nxt = pending + (biu_stb_ack_i ? len(owner type) : 0) - (biu_ack_i ? 1 : 0).
  - biu_err_i forces pending_nxt = 0, overriding the other terms.
  - Ack while pending = 0 and no stb_ack that cycle: protocol violation; assertion fires and pending stays 0 (no underflow).
- BUSY -> IDLE when all of the following hold this cycle:
  - pending_nxt == 0;
  - no biu_stb_ack_i;
  - owner stb low;
  - owner lock low.
- Back-to-back strobes from the owner keep BUSY and never re-arbitrate.
- Owner lock high holds ownership indefinitely, even with pending = 0.
- Error:
  - Route to the owner; pending = 0.
  - Return to IDLE the next cycle if stb and lock are low.
  - If the owner re-strobes, BUSY continues.
- The losing port waits with stb high and receives no acknowledges.
- Reset mid-transfer: all state returns to reset values immediately at the clock edge; any in-flight BIU beats are discarded (the BIU is reset together).

Test Plan:
1. I strobes SINGLE read at 0x100, D idle -> biu_adri_o = 0x100; ibiu_stb_ack_o on the BIU ack; one ibiu_ack_o; dbiu_* acks stay 0; back to IDLE after the ack.
2. I and D both strobe in the same cycle after reset -> I is granted first. D (INCR8) is granted only after I's final ack, then receives 8 dbiu_ack_o. The next tie goes to I.
3. D issues WRAP4, then back-to-back SINGLE while the wrap data is still pending -> pending peaks at 4 then 5, with no re-arbitration. An I strobe in the meantime waits until pending = 0 and D's stb is low.
4. BIU asserts biu_err_i on beat 2 of an I INCR4 -> ibiu_err_o pulses 1 cycle; pending = 0; D, waiting, is granted the following cycle.
5. D holds lock = 1 across two SINGLE transfers with an idle gap, while I requests -> I is not granted until D's lock drops.
6. HRESET asserted with pending = 7 -> the next cycle has fsm = IDLE, pending = 0, all acks 0, biu_stb_o follows a fresh arbitration.
